// File: rtl/ex_pkg.sv
// Shared types for the sequential multiply/divide unit: op encodings, FSM states
// and a small conditional-negate helper.
package ex_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_t;

  function automatic logic [31:0] neg32(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-divide iteration: shift {rem,quo} left by one, subtract the
// divisor when it fits and shift the resulting quotient bit in at the bottom.
module muldiv_div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] div_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] trial;
  logic [32:0] diff;

  always_comb begin
    trial = {rem_i, quo_i[31]};
    diff  = trial - {1'b0, div_i};
    // rem_i < div_i, so a non-negative difference always fits in 32 bits
    if (!diff[32]) begin
      rem_o = diff[31:0];
      quo_o = {quo_i[30:0], 1'b1};
    end else begin
      rem_o = trial[31:0];
      quo_o = {quo_i[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// Sequential RV32M multiply/divide unit: magnitude datapath, 32 radix-2 steps,
// sign fix-up on DONE entry. Define MULDIV_FAST_MUL_EN for single-cycle multiply.
module ex_muldiv_seq
  import ex_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  muldiv_op_t       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  muldiv_state_t    state_q, state_d;
  muldiv_op_t       op_q, op_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [63:0]      acc_q, acc_d;      // mul: {hi, lo/multiplier}; div: {rem, quo}
  logic [31:0]      opb_q, opb_d;      // multiplicand or divisor magnitude
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             neg_q_q, neg_q_d;  // negate product / quotient
  logic             neg_r_q, neg_r_d;  // negate remainder
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;

  logic        a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [31:0] a_mag, b_mag, div_rem, div_quo, result;
  logic [32:0] mul_sum;
  logic [63:0] mul_next, prod;

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_tag   = resp_tag_q;

  always_comb begin
    a_sgn    = (req_op == OP_MULH) || (req_op == OP_MULHSU) ||
               (req_op == OP_DIV)  || (req_op == OP_REM);
    b_sgn    = (req_op == OP_MULH) || (req_op == OP_DIV) || (req_op == OP_REM);
    a_neg    = a_sgn && req_a[31];
    b_neg    = b_sgn && req_b[31];
    a_mag    = neg32(req_a, a_neg);
    b_mag    = neg32(req_b, b_neg);
    div_zero = req_op[2] && (req_b == 32'd0);
    div_ovf  = ((req_op == OP_DIV) || (req_op == OP_REM)) &&
               (req_a == 32'h8000_0000) && (req_b == 32'hFFFF_FFFF);
  end

  muldiv_div_step u_div_step (
    .rem_i (acc_q[63:32]),
    .quo_i (acc_q[31:0]),
    .div_i (opb_q),
    .rem_o (div_rem),
    .quo_o (div_quo)
  );

  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
    prod     = neg_q_q ? (~acc_q + 64'd1) : acc_q;
    case (op_q)
      OP_MUL:                      result = prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod[63:32];
      OP_DIV, OP_DIVU:             result = neg32(acc_q[31:0], neg_q_q);
      default:                     result = neg32(acc_q[63:32], neg_r_q);
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    opb_d        = opb_q;
    tag_d        = tag_q;
    neg_q_d      = neg_q_q;
    neg_r_d      = neg_r_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_tag_d   = resp_tag_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          tag_d   = req_tag;
          opb_d   = b_mag;
          cnt_d   = 5'd0;
          neg_q_d = a_neg ^ b_neg;
          neg_r_d = a_neg;
          acc_d   = {32'd0, a_mag};
          state_d = ST_CALC;
          // Corner cases bypass iteration with the architectural results preloaded
          if (div_zero) begin
            acc_d   = {req_a, 32'hFFFF_FFFF};
            neg_q_d = 1'b0;
            neg_r_d = 1'b0;
            state_d = ST_DONE;
          end else if (div_ovf) begin
            acc_d   = {32'd0, 32'h8000_0000};
            neg_q_d = 1'b0;
            neg_r_d = 1'b0;
            state_d = ST_DONE;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!req_op[2]) begin
            acc_d   = {32'd0, a_mag} * {32'd0, b_mag};
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_CALC: begin
        acc_d = op_q[2] ? {div_rem, div_quo} : mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ST_DONE;
      end
      ST_DONE: begin
        // First DONE cycle registers the sign-corrected result
        if (!resp_valid_q) begin
          resp_valid_d = 1'b1;
          resp_data_d  = result;
          resp_tag_d   = tag_q;
        end else if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_MUL;
      cnt_q        <= 5'd0;
      acc_q        <= 64'd0;
      opb_q        <= 32'd0;
      tag_q        <= '0;
      neg_q_q      <= 1'b0;
      neg_r_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      resp_tag_q   <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      opb_q        <= opb_d;
      tag_q        <= tag_d;
      neg_q_q      <= neg_q_d;
      neg_r_q      <= neg_r_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
    end
  end

endmodule

// File: doc/ex_muldiv_seq.md
EX_MULDIV_SEQ -- requirements
Module: ex_muldiv_seq

Interface
REQ-001 SHALL have parameter: TAG_W, default 5, width of destination-register tag carried with each operation.
REQ-002 SHALL have port: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: req_valid  in  1  execute stage presents an operation.
REQ-005 SHALL have port: req_ready  out  1  unit accepts an operation this cycle.
REQ-006 SHALL have port: req_op  in  3  muldiv_op_t: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-007 SHALL have ports: req_a, req_b  in  32 each  operands rs1 and rs2.
REQ-008 SHALL have port: req_tag  in  TAG_W  destination tag.
REQ-009 SHALL have port: resp_valid  out  1  result available.
REQ-010 SHALL have port: resp_ready  in  1  writeback consumes the result.
REQ-011 SHALL have ports: resp_data  out  32, resp_tag  out  TAG_W  result and its tag.
REQ-012 SHALL have port: busy  out  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM IDLE, CALC, DONE; req_ready = (state == IDLE).
REQ-014 SHALL accept when req_valid && req_ready; latch op, tag, operand magnitudes and result sign flags; IDLE -> CALC, iteration counter = 0.
REQ-015 SHALL hold req_a/req_b/req_op don't-care once accepted; latched copies only are used.
REQ-016 SHALL, in CALC, do one radix-2 step per cycle (shift-add multiply into 64-bit accumulator; restoring divide on 32-bit quotient/remainder); after step 31 go to DONE.
REQ-017 SHALL assert resp_valid in DONE only; resp_valid rises exactly 33 cycles after the accept edge for iterative ops.
REQ-018 SHALL keep resp_data/resp_tag stable while resp_valid && !resp_ready; DONE -> IDLE on resp_valid && resp_ready; no new accept in that same cycle (req_ready rises next cycle).
REQ-019 SHALL select results: MUL low 32 of product; MULH/MULHSU/MULHU high 32 with signed x signed, signed x unsigned, unsigned x unsigned; DIV/REM signed truncating toward zero, remainder sign = dividend sign; DIVU/REMU unsigned.
REQ-020 SHALL, for divide by zero, skip CALC and enter DONE next cycle: quotient 32'hFFFF_FFFF, remainder = req_a.
REQ-021 SHALL, for signed overflow (a = 32'h8000_0000, b = 32'hFFFF_FFFF, DIV/REM), skip CALC: quotient 32'h8000_0000, remainder 0.
REQ-022 SHALL compute sign correction (two's-complement negate) in the DONE-entry cycle, never on the combinational resp path.

Reset
REQ-023 SHALL, on rst high at a clock edge, force state IDLE, counter 0, resp_valid 0, busy 0, resp_data 0, resp_tag 0, req_ready 1 on the following cycle.
REQ-024 SHALL discard any in-flight CALC or unconsumed DONE result on rst; no response is ever produced for it.

Configuration
REQ-025 SHALL honour macro MULDIV_FAST_MUL_EN: defined -> MUL* ops compute a full 64-bit product in one cycle and reach DONE on the cycle after accept (resp_valid 1 cycle after accept); undefined -> MUL* ops use the 32-step iterative path of REQ-016/REQ-017. Divide behaviour is identical in both builds.

Structure
REQ-026 SHALL place muldiv_op_t, its encodings and state enum muldiv_state_t in shared package ex_pkg.
REQ-027 SHALL implement the per-cycle divide step as sub-module muldiv_div_step (32-bit remainder/quotient in, shifted pair out, combinational).

Verification
REQ-028 SHALL cover: DIVU a=100, b=7, tag=3 -> resp_valid 33 cycles after accept, resp_data=14, resp_tag=3; REMU same -> 2.
REQ-029 SHALL cover: DIV a=-7 (32'hFFFF_FFF9), b=2 -> 32'hFFFF_FFFD; REM same -> 32'hFFFF_FFFF.
REQ-030 SHALL cover: DIV a=5, b=0 -> 32'hFFFF_FFFF one cycle after accept; REM a=5, b=0 -> 5; DIV 32'h8000_0000 / 32'hFFFF_FFFF -> 32'h8000_0000.
REQ-031 SHALL cover: MULH a=32'h8000_0000, b=2 -> 32'hFFFF_FFFF; MULHU same -> 1; MUL same -> 0; latency 33 without macro, 1 with MULDIV_FAST_MUL_EN.
REQ-032 SHALL cover: resp_ready held low 10 cycles in DONE -> resp_data/resp_tag stable, req_ready low, then single handshake and return to IDLE.
REQ-033 SHALL cover: rst pulsed mid-CALC (cycle 15) -> no resp_valid ever for that op; next DIVU 9/3 -> 3 with correct tag.
